fp_norm_round: RTL and testbench

Multi-cycle normalise-and-round stage that sits directly downstream of the single-precision adder core. It accepts a raw, unnormalised sum: sign, exponent, a 25-bit mantissa with carry and hidden bits, and guard/round/sticky bits. It normalises the mantissa one bit per cycle and rounds to nearest-even. It then emits a packed IEEE-754 binary32 result with exception flags over a valid/ready handshake.

---
 rtl/fp_pkg.sv | 19 +
 rtl/fp_norm_round_if.sv | 27 ++
 rtl/fp_round_rne.sv | 27 ++
 rtl/fp_norm_round.sv | 149 ++++++++++++++
 tb/tb_fp_norm_round.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point constants, FSM state type and flag bit positions.
package fp_pkg;
  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;

  // Positions within the {overflow, underflow, inexact} flag vector
  localparam int OVF = 2;
  localparam int UNF = 1;
  localparam int INX = 0;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    ROUND,
    HOLD
  } state_t;
endpackage

// File: rtl/fp_norm_round_if.sv
// Raw-sum input and packed-result output handshake of the normalise/round stage.
interface fp_norm_round_if;
  import fp_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic               in_sign;
  logic [EXP_W-1:0]   in_exp;
  logic [MAN_W+1:0]   in_mant;
  logic [2:0]         in_grs;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_result;
  logic [2:0]         out_flags;

  // Producer of raw sums and consumer of results
  modport master (
    output in_valid, in_sign, in_exp, in_mant, in_grs, out_ready,
    input  in_ready, out_valid, out_result, out_flags
  );

  // The normalise/round stage itself
  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, in_grs, out_ready,
    output in_ready, out_valid, out_result, out_flags
  );
endinterface

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a normalised 24-bit significand (bit 24 = carry).
// A carry out of the increment renormalises the significand to 1.0.
module fp_round_rne
  import fp_pkg::*;
(
  input  logic [MAN_W+1:0] i_mant,
  input  logic             i_g,
  input  logic             i_r,
  input  logic             i_s,
  output logic [MAN_W+1:0] o_mant,
  output logic             o_carry,
  output logic             o_inexact
);

  logic             w_inc;
  logic [MAN_W+1:0] w_sum;

  // Increment when above half, or exactly half with an odd LSB
  always_comb begin
    w_inc     = i_g & (i_r | i_s | i_mant[0]);
    w_sum     = i_mant + {{(MAN_W+1){1'b0}}, w_inc};
    o_carry   = w_sum[MAN_W+1];
    o_mant    = o_carry ? {2'b01, {MAN_W{1'b0}}} : w_sum;
    o_inexact = i_g | i_r | i_s;
  end

endmodule

// File: rtl/fp_norm_round.sv
// Normalise (one bit per cycle) and round-to-nearest-even stage for the
// single-precision adder; emits packed binary32 plus exception flags.
module fp_norm_round
  import fp_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  fp_norm_round_if.slave bus
);

  localparam logic [EXP_W:0] EXP_ONE = (EXP_W+1)'(1);
  localparam logic [EXP_W:0] EXP_TOP = (EXP_W+1)'(EXP_MAX);

  state_t           r_state, w_state_nxt;
  logic             r_sign, w_sign_nxt;
  logic [EXP_W:0]   r_exp, w_exp_nxt;
  logic [MAN_W+1:0] r_mant, w_mant_nxt;
  logic             r_g, r_r, r_s;
  logic             w_g_nxt, w_r_nxt, w_s_nxt;
  logic [31:0]      r_result, w_result_nxt;
  logic [2:0]       r_flags, w_flags_nxt;

  logic [EXP_W:0]   w_exp_dec;
  logic [EXP_W:0]   w_exp_rnd;
  logic [MAN_W+1:0] w_rnd_mant;
  logic             w_rnd_carry;
  logic             w_rnd_inexact;

  fp_round_rne u_rne (
    .i_mant    (r_mant),
    .i_g       (r_g),
    .i_r       (r_r),
    .i_s       (r_s),
    .o_mant    (w_rnd_mant),
    .o_carry   (w_rnd_carry),
    .o_inexact (w_rnd_inexact)
  );

  assign bus.in_ready   = (r_state == IDLE);
  assign bus.out_valid  = (r_state == HOLD);
  assign bus.out_result = r_result;
  assign bus.out_flags  = r_flags;

  // Next-state and datapath update; each SHIFT cycle applies exactly one rule
  always_comb begin
    w_state_nxt  = r_state;
    w_sign_nxt   = r_sign;
    w_exp_nxt    = r_exp;
    w_mant_nxt   = r_mant;
    w_g_nxt      = r_g;
    w_r_nxt      = r_r;
    w_s_nxt      = r_s;
    w_result_nxt = r_result;
    w_flags_nxt  = r_flags;
    w_exp_dec    = r_exp - EXP_ONE;
    w_exp_rnd    = r_exp + {{EXP_W{1'b0}}, w_rnd_carry};

    unique case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_sign_nxt  = bus.in_sign;
          w_exp_nxt   = {1'b0, bus.in_exp};
          w_mant_nxt  = bus.in_mant;
          w_g_nxt     = bus.in_grs[2];
          w_r_nxt     = bus.in_grs[1];
          w_s_nxt     = bus.in_grs[0];
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (r_exp == EXP_TOP) begin
          w_result_nxt = {r_sign, {EXP_W{1'b1}}, r_mant[MAN_W-1:0]};
          w_flags_nxt  = '0;
          w_state_nxt  = HOLD;
        end else if (r_mant == '0 && !(r_g | r_r | r_s)) begin
          w_result_nxt = '0;
          w_flags_nxt  = '0;
          w_state_nxt  = HOLD;
        end else if (r_mant[MAN_W+1]) begin
          w_mant_nxt  = {1'b0, r_mant[MAN_W+1:1]};
          w_g_nxt     = r_mant[0];
          w_r_nxt     = r_g;
          w_s_nxt     = r_r | r_s;
          w_exp_nxt   = r_exp + EXP_ONE;
          w_state_nxt = ROUND;
        end else if (r_mant[MAN_W]) begin
          w_state_nxt = ROUND;
        end else begin
          w_mant_nxt = {r_mant[MAN_W:0], r_g};
          w_g_nxt    = r_r;
          w_r_nxt    = 1'b0;
          w_exp_nxt  = w_exp_dec;
          if (w_exp_dec == '0) begin
            w_result_nxt     = {r_sign, {(EXP_W+MAN_W){1'b0}}};
            w_flags_nxt      = '0;
            w_flags_nxt[UNF] = 1'b1;
            w_flags_nxt[INX] = 1'b1;
            w_state_nxt      = HOLD;
          end
        end
      end
      ROUND: begin
        w_mant_nxt       = w_rnd_mant;
        w_exp_nxt        = w_exp_rnd;
        w_flags_nxt      = '0;
        w_flags_nxt[INX] = w_rnd_inexact;
        if (w_exp_rnd >= EXP_TOP) begin
          w_result_nxt     = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          w_flags_nxt[OVF] = 1'b1;
        end else begin
          w_result_nxt = {r_sign, w_exp_rnd[EXP_W-1:0], w_rnd_mant[MAN_W-1:0]};
        end
        w_state_nxt = HOLD;
      end
      HOLD: begin
        if (bus.out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_sign   <= 1'b0;
      r_exp    <= '0;
      r_mant   <= '0;
      r_g      <= 1'b0;
      r_r      <= 1'b0;
      r_s      <= 1'b0;
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_sign   <= w_sign_nxt;
      r_exp    <= w_exp_nxt;
      r_mant   <= w_mant_nxt;
      r_g      <= w_g_nxt;
      r_r      <= w_r_nxt;
      r_s      <= w_s_nxt;
      r_result <= w_result_nxt;
      r_flags  <= w_flags_nxt;
    end
  end

endmodule

// File: tb/tb_fp_norm_round.sv
// Testbench for fp_norm_round: directed cases plus randomized raw sums
// checked against an arithmetic reference model.
module tb_fp_norm_round;
  import fp_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_norm_round_if u_if ();

  fp_norm_round u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, want);
  endtask

  // Reference: treat {mant,g,r} as an integer significand with s as sticky,
  // locate the leading one, scale to 24 bits, then round half-to-even.
  function automatic void model(input logic sgn, input int e_in, input logic [24:0] m,
                                input logic [2:0] grs, output logic [31:0] res,
                                output logic [2:0] fl, output int lat);
    longint unsigned v;
    longint unsigned keep;
    int  msb, e, sh, rem;
    bit  stk, up;
    v   = longint'({m, grs[2:1]});
    stk = grs[0];
    fl  = '0;
    res = '0;
    if (e_in == EXP_MAX) begin
      res = {sgn, 8'hFF, m[22:0]};
      lat = 2;
      return;
    end
    if (v == 0 && !stk) begin
      lat = 2;
      return;
    end
    msb = -1;
    for (int i = 0; i < 27; i++) if (v[i]) msb = i;
    e = e_in;
    if (msb == 26) begin
      stk = stk | v[0];
      v   = v >> 1;
      e   = e + 1;
      lat = 3;
    end else if (msb == 25) begin
      lat = 3;
    end else begin
      sh = (msb < 0) ? 1000 : 25 - msb;
      if (e_in <= sh) begin
        res = {sgn, 31'b0};
        fl  = 3'b011;
        lat = 1 + e_in;
        return;
      end
      v   = v << sh;
      e   = e - sh;
      lat = 3 + sh;
    end
    keep = v >> 2;
    rem  = int'(v[1:0]) * 2 + int'(stk);
    up   = (rem > 4) || (rem == 4 && keep[0]);
    keep = keep + longint'(up);
    if (keep == (64'd1 << 24)) begin
      keep = 64'd1 << 23;
      e    = e + 1;
    end
    fl[INX] = (rem != 0);
    if (e >= EXP_MAX) begin
      res     = {sgn, 8'hFF, 23'b0};
      fl[OVF] = 1'b1;
    end else begin
      res = {sgn, e[7:0], keep[22:0]};
    end
  endfunction

  task automatic run_op(input string tag, input logic sgn, input logic [7:0] e,
                        input logic [24:0] m, input logic [2:0] grs,
                        input logic [31:0] w_res, input logic [2:0] w_fl,
                        input int w_lat, input int hold_cyc);
    int lat;
    int guard;
    guard = 0;
    while (!u_if.in_ready && guard < 1000) begin
      @(posedge clk); #1;
      guard++;
    end
    chk({tag, ".rdy"}, 32'(u_if.in_ready), 32'd1);
    u_if.in_sign  = sgn;
    u_if.in_exp   = e;
    u_if.in_mant  = m;
    u_if.in_grs   = grs;
    u_if.in_valid = 1'b1;
    @(posedge clk); #1;
    u_if.in_valid = 1'b0;
    lat = 1;
    while (!u_if.out_valid && lat < 600) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".lat"}, 32'(lat), 32'(w_lat));
    chk({tag, ".res"}, u_if.out_result, w_res);
    chk({tag, ".flg"}, 32'(u_if.out_flags), 32'(w_fl));
    for (int i = 0; i < hold_cyc; i++) begin
      u_if.in_valid = 1'b1;
      u_if.in_exp   = 8'(i + 3);
      u_if.in_mant  = 25'h0A5A5A5 + 25'(i);
      @(posedge clk); #1;
      chk({tag, ".hold_res"}, u_if.out_result, w_res);
      chk({tag, ".hold_rdy"}, 32'(u_if.in_ready), 32'd0);
    end
    u_if.in_valid  = 1'b0;
    u_if.out_ready = 1'b1;
    @(posedge clk); #1;
    u_if.out_ready = 1'b0;
    chk({tag, ".done_vld"}, 32'(u_if.out_valid), 32'd0);
    chk({tag, ".done_rdy"}, 32'(u_if.in_ready), 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] m_res;
    logic [2:0]  m_fl;
    int          m_lat;
    logic        sgn;
    logic [7:0]  e;
    logic [24:0] mm;
    logic [2:0]  grs;
    int          k;

    rst            = 1'b1;
    u_if.in_valid  = 1'b0;
    u_if.in_sign   = 1'b0;
    u_if.in_exp    = '0;
    u_if.in_mant   = '0;
    u_if.in_grs    = '0;
    u_if.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.rdy", 32'(u_if.in_ready), 32'd1);
    chk("rst.vld", 32'(u_if.out_valid), 32'd0);
    chk("rst.res", u_if.out_result, 32'd0);
    chk("rst.flg", 32'(u_if.out_flags), 32'd0);
    rst = 1'b0;

    run_op("carry",   1'b0, 8'd127, 25'h1000000, 3'b000, 32'h40000000, 3'b000, 3, 0);
    run_op("cancel",  1'b0, 8'd127, 25'h0200000, 3'b000, 32'h3E800000, 3'b000, 5, 0);
    run_op("unf",     1'b0, 8'd1,   25'h0400000, 3'b000, 32'h00000000, 3'b011, 2, 0);
    run_op("unf_neg", 1'b1, 8'd1,   25'h0400000, 3'b000, 32'h80000000, 3'b011, 2, 0);
    run_op("rne_up",  1'b0, 8'd127, 25'h0800001, 3'b100, 32'h3F800002, 3'b001, 3, 0);
    run_op("rne_tie", 1'b0, 8'd127, 25'h0800000, 3'b100, 32'h3F800000, 3'b001, 3, 0);
    run_op("ovf",     1'b0, 8'd254, 25'h1FFFFFF, 3'b000, 32'h7F800000, 3'b101, 3, 0);
    run_op("pass",    1'b1, 8'd255, 25'h0412345, 3'b111, 32'hFFC12345, 3'b000, 2, 0);
    run_op("zero",    1'b1, 8'd100, 25'h0000000, 3'b000, 32'h00000000, 3'b000, 2, 0);
    run_op("bp",      1'b0, 8'd127, 25'h0800001, 3'b100, 32'h3F800002, 3'b001, 3, 10);

    // Abort a multi-shift operation while still in SHIFT
    u_if.in_sign  = 1'b0;
    u_if.in_exp   = 8'd127;
    u_if.in_mant  = 25'h0200000;
    u_if.in_grs   = 3'b000;
    u_if.in_valid = 1'b1;
    @(posedge clk); #1;
    u_if.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort.rdy", 32'(u_if.in_ready), 32'd1);
    chk("abort.vld", 32'(u_if.out_valid), 32'd0);
    chk("abort.res", u_if.out_result, 32'd0);
    chk("abort.flg", 32'(u_if.out_flags), 32'd0);
    repeat (6) begin
      @(posedge clk); #1;
      chk("abort.quiet", 32'(u_if.out_valid), 32'd0);
    end

    for (int n = 0; n < 200; n++) begin
      sgn = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0:       e = 8'd255;
        1:       e = 8'($urandom_range(1, 24));
        2:       e = 8'($urandom_range(240, 254));
        default: e = 8'(BIAS - 30 + int'($urandom_range(0, 60)));
      endcase
      k = int'($urandom_range(0, 25)) - 1;
      if (k < 0) mm = '0;
      else       mm = (25'($urandom) & ((25'd1 << k) - 25'd1)) | (25'd1 << k);
      if ($urandom_range(0, 9) == 0) mm = 25'h0FFFFFF;
      grs = 3'($urandom);
      model(sgn, int'(e), mm, grs, m_res, m_fl, m_lat);
      run_op($sformatf("rnd%0d", n), sgn, e, mm, grs, m_res, m_fl, m_lat,
             int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
